// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared defaults and id-width helper for the round-robin adder arbiter
package adder_arb_pkg;

    localparam int ARB_NUM_REQ = 4;
    localparam int ARB_WIDTH   = 16;
    localparam int ARB_CNT_W   = 16;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// carry_lookahead_adder: unsigned adder with every carry formed as a flat generate/propagate sum of products
module carry_lookahead_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    logic [WIDTH-1:0] w_g;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH:0]   w_c;
    logic             w_t;
    logic             w_pp;

    // Each carry c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1..0]cin, with no dependence on other carries
    always_comb begin
        w_g  = i_a & i_b;
        w_p  = i_a ^ i_b;
        w_c  = '0;
        w_t  = 1'b0;
        w_pp = 1'b1;
        for (int i = 0; i <= WIDTH; i++) begin
            w_t  = 1'b0;
            w_pp = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                w_t  = w_t | (w_pp & w_g[j]);
                w_pp = w_pp & w_p[j];
            end
            w_c[i] = w_t | (w_pp & i_cin);
        end
    end

    assign o_sum  = w_p ^ w_c[WIDTH-1:0];
    assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector starting its search at the pointer
module rr_picker
    import adder_arb_pkg::*;
#(
    parameter  int NUM_REQ = ARB_NUM_REQ,
    localparam int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_pos;

    // Walk ptr, ptr+1, ... modulo NUM_REQ and take the first valid request
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_sum = '0;
        w_pos = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, i_ptr} + (ID_W+1)'(k);
            w_pos = (w_sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(w_sum - (ID_W+1)'(NUM_REQ)) : ID_W'(w_sum);
            if (i_en && !o_any && i_req[w_pos]) begin
                o_gnt[w_pos] = 1'b1;
                o_idx        = w_pos;
                o_any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: round-robin sharing of one carry-lookahead adder; ADDER_ARB_STATS_EN adds per-requester grant counters
module adder_rr_arbiter
    import adder_arb_pkg::*;
#(
    parameter  int NUM_REQ = ARB_NUM_REQ,
    parameter  int WIDTH   = ARB_WIDTH,
    parameter  int CNT_W   = ARB_CNT_W,
    localparam int ID_W    = id_w(NUM_REQ)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NUM_REQ-1:0]       i_req_valid,
    output logic [NUM_REQ-1:0]       o_req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_add1,
    input  logic [NUM_REQ*WIDTH-1:0] i_req_add2,
    output logic                     o_res_valid,
    input  logic                     i_res_ready,
    output logic [WIDTH:0]           o_res_data,
    output logic [ID_W-1:0]          o_res_id
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0] o_grant_cnt
`endif
);

    if (NUM_REQ < 1 || WIDTH < 1 || CNT_W < 1) begin : g_bad_cfg
        $error("adder_rr_arbiter: NUM_REQ, WIDTH and CNT_W must all be at least 1");
    end

    logic                 r_res_valid;
    logic [WIDTH:0]       r_res_data;
    logic [ID_W-1:0]      r_res_id;
    logic [ID_W-1:0]      r_rr_ptr;
    logic                 w_load;
    logic [NUM_REQ-1:0]   w_gnt;
    logic [ID_W-1:0]      w_idx;
    logic                 w_any;
    logic [ID_W-1:0]      w_ptr_nxt;
    logic [WIDTH-1:0]     w_a;
    logic [WIDTH-1:0]     w_b;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_cout;

    // The output slot can take a new result when empty or being drained this cycle
    assign w_load      = ~r_res_valid | i_res_ready;
    assign o_req_ready = w_gnt;
    assign w_ptr_nxt   = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req (i_req_valid),
        .i_ptr (r_rr_ptr),
        .i_en  (w_load),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // One-hot AND-OR mux steers the granted requester's operands into the adder
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_a = w_a | (i_req_add1[k*WIDTH +: WIDTH] & {WIDTH{w_gnt[k]}});
            w_b = w_b | (i_req_add2[k*WIDTH +: WIDTH] & {WIDTH{w_gnt[k]}});
        end
    end

    carry_lookahead_adder #(
        .WIDTH (WIDTH)
    ) u_cla (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // Output register and pointer advance only when the slot is free; data/id hold when idle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            r_res_valid <= w_any;
            if (w_any) begin
                r_res_data <= {w_cout, w_sum};
                r_res_id   <= w_idx;
                r_rr_ptr   <= w_ptr_nxt;
            end
        end
    end

    assign o_res_valid = r_res_valid;
    assign o_res_data  = r_res_data;
    assign o_res_id    = r_res_id;

`ifdef ADDER_ARB_STATS_EN
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        // Saturating count of transfers by requester k
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)
                r_cnt <= '0;
            else if (w_gnt[k] && !(&r_cnt))
                r_cnt <= r_cnt + 1'b1;
        end
        assign o_grant_cnt[k*CNT_W +: CNT_W] = r_cnt;
    end
`endif

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// tb_adder_rr_arbiter: directed-vector self-checking bench for adder_rr_arbiter
module tb_adder_rr_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [3:0]  i_req_valid = '0;
    logic [3:0]  o_req_ready;
    logic [63:0] i_req_add1 = '0;
    logic [63:0] i_req_add2 = '0;
    logic        o_res_valid;
    logic        i_res_ready = 1'b0;
    logic [16:0] o_res_data;
    logic [1:0]  o_res_id;
`ifdef ADDER_ARB_STATS_EN
    logic [63:0] o_grant_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int          seq [6]  = '{1, 2, 3, 0, 1, 2};
    logic [16:0] sums [4] = '{17'h0001F, 17'h002FF, 17'h03FFF, 17'h10001};

    adder_rr_arbiter u_dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_add1  (i_req_add1),
        .i_req_add2  (i_req_add2),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_res_data  (o_res_data),
        .o_res_id    (o_res_id)
`ifdef ADDER_ARB_STATS_EN
        ,
        .o_grant_cnt (o_grant_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12 i_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("idle_valid", 32'(o_res_valid), 32'h0);
            check("idle_data", 32'(o_res_data), 32'h0);
            check("idle_id", 32'(o_res_id), 32'h0);
            check("idle_ready", 32'(o_req_ready), 32'h0);
        end
        i_res_ready = 1'b1;
        i_req_add1  = {16'h8000, 16'h3000, 16'h0200, 16'hFFFF};
        i_req_add2  = {16'h8001, 16'h0FFF, 16'h00FF, 16'h0001};
        i_req_valid = 4'b0001;
        #1 check("single_ready", 32'(o_req_ready), 32'h1);
        tick();
        check("single_valid", 32'(o_res_valid), 32'h1);
        check("single_data", 32'(o_res_data), 32'h10000);
        check("single_id", 32'(o_res_id), 32'h0);
        i_req_add1  = {16'h8000, 16'h3000, 16'h0200, 16'h0010};
        i_req_add2  = {16'h8001, 16'h0FFF, 16'h00FF, 16'h000F};
        i_req_valid = 4'b1111;
        for (int c = 0; c < 6; c++) begin
            #1 check("rr_ready", 32'(o_req_ready), 32'h1 << seq[c]);
            tick();
            check("rr_valid", 32'(o_res_valid), 32'h1);
            check("rr_id", 32'(o_res_id), 32'(seq[c]));
            check("rr_data", 32'(o_res_data), 32'(sums[seq[c]]));
        end
        i_res_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1 check("bp_ready", 32'(o_req_ready), 32'h0);
            tick();
            check("bp_valid", 32'(o_res_valid), 32'h1);
            check("bp_id", 32'(o_res_id), 32'h2);
            check("bp_data", 32'(o_res_data), 32'h03FFF);
        end
        i_res_ready = 1'b1;
        #1 check("release_ready", 32'(o_req_ready), 32'h8);
        tick();
        check("release_id", 32'(o_res_id), 32'h3);
        check("release_data", 32'(o_res_data), 32'h10001);
        i_req_valid = 4'b1001;
        #1 check("wrap_ready0", 32'(o_req_ready), 32'h1);
        tick();
        check("wrap_id0", 32'(o_res_id), 32'h0);
        #1 check("wrap_ready3", 32'(o_req_ready), 32'h8);
        tick();
        check("wrap_id3", 32'(o_res_id), 32'h3);
        i_req_valid = 4'b0000;
        #1 check("empty_ready", 32'(o_req_ready), 32'h0);
        tick();
        check("empty_valid", 32'(o_res_valid), 32'h0);
        i_req_valid = 4'b1111;
        #1 check("pre_rst_ready", 32'(o_req_ready), 32'h1);
        tick();
        check("pre_rst_id", 32'(o_res_id), 32'h0);
        #1 check("pre_rst_ptr", 32'(o_req_ready), 32'h2);
        #1 i_rst = 1'b1;
        #1 check("rst_valid", 32'(o_res_valid), 32'h0);
        check("rst_data", 32'(o_res_data), 32'h0);
        check("rst_id", 32'(o_res_id), 32'h0);
        #1 i_rst = 1'b0;
        #1 check("post_rst_ready", 32'(o_req_ready), 32'h1);
        tick();
        check("post_rst_id", 32'(o_res_id), 32'h0);
        check("post_rst_data", 32'(o_res_data), 32'h0001F);
`ifdef ADDER_ARB_STATS_EN
        i_req_valid = 4'b0100;
        for (int c = 0; c < 5; c++) tick();
        check("cnt2", o_grant_cnt[47:32], 32'h5);
        check("cnt0", o_grant_cnt[15:0], 32'h1);
        check("cnt1", o_grant_cnt[31:16], 32'h0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
